stream_rr_arbiter: RTL and testbench

- Shares one downstream stream sink, typically a stream_fifo, between N_REQ upstream requesters.
- Round-robin grant at packet granularity: the grant is held until the granted source's last beat is accepted, or until a MAX_BEATS watchdog forces release.
- Passes the granted source's data through to the master side combinationally and tags it with the source index.

---
 rtl/stream_arb_pkg.sv | 20 ++
 rtl/stream_rr_arbiter_if.sv | 30 +++
 rtl/rr_picker.sv | 43 ++++
 rtl/stream_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_stream_rr_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Wrapped increment of a requester index in the range [0, n-1].
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    int unsigned nxt;
    if (ptr >= n - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle between N_REQ requesters, the arbiter and one downstream sink.
interface stream_rr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(N_REQ)
) ();

  logic [N_REQ*DATA_WIDTH-1:0] s_data_i;
  logic [N_REQ-1:0]            s_valid_i;
  logic [N_REQ-1:0]            s_last_i;
  logic [N_REQ-1:0]            s_ready_o;
  logic [DATA_WIDTH-1:0]       m_data_o;
  logic                        m_valid_o;
  logic                        m_last_o;
  logic [ID_WIDTH-1:0]         m_id_o;
  logic                        m_ready_i;

  // Arbiter view.
  modport slave (
    input  s_data_i, s_valid_i, s_last_i, m_ready_i,
    output s_ready_o, m_data_o, m_valid_o, m_last_o, m_id_o
  );

  // Environment view: requesters plus downstream sink.
  modport master (
    output s_data_i, s_valid_i, s_last_i, m_ready_i,
    input  s_ready_o, m_data_o, m_valid_o, m_last_o, m_id_o
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i,
// searching cyclically over all N_REQ indices.
module rr_picker #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]    req_i,
  input  logic [ID_WIDTH-1:0] rr_ptr_i,
  output logic                found_o,
  output logic [ID_WIDTH-1:0] idx_o
);

  localparam logic [ID_WIDTH:0] N_L = (ID_WIDTH+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl_s;
  logic [N_REQ-1:0]   rot_s;
  logic [ID_WIDTH-1:0] off_s;
  logic [ID_WIDTH:0]   sum_s;

  // Rotate so bit 0 is the requester at rr_ptr_i, then take the lowest set bit.
  always_comb begin
    dbl_s   = {req_i, req_i};
    rot_s   = N_REQ'(dbl_s >> rr_ptr_i);
    found_o = 1'b0;
    off_s   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        found_o = 1'b1;
        off_s   = ID_WIDTH'(i);
      end else begin
        found_o = found_o;
        off_s   = off_s;
      end
    end
    sum_s = {1'b0, rr_ptr_i} + {1'b0, off_s};
    if (sum_s >= N_L) begin
      idx_o = ID_WIDTH'(sum_s - N_L);
    end else begin
      idx_o = sum_s[ID_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one stream sink between N_REQ
// requesters, with a MAX_BEATS watchdog that forces end-of-packet.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256,
  parameter int ID_WIDTH   = $clog2(N_REQ),
  parameter int CNT_WIDTH  = $clog2(MAX_BEATS + 1)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  stream_rr_arbiter_if.slave   bus,
  output logic                 busy_o,
  output logic                 timeout_o
);

  arb_state_t           state_q, state_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 timeout_q, timeout_d;

  logic [DATA_WIDTH-1:0] data_arr_s [N_REQ];
  logic                  in_grant_s;
  logic                  sel_valid_s;
  logic                  sel_last_s;
  logic                  wd_last_s;
  logic                  m_valid_s;
  logic                  m_last_s;
  logic                  accept_s;
  logic                  found_s;
  logic [ID_WIDTH-1:0]   pick_idx_s;

  rr_picker #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req_i    (bus.s_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (found_s),
    .idx_o    (pick_idx_s)
  );

  // Datapath mux and handshake; ready depends only on grant and m_ready_i.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      data_arr_s[k] = bus.s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
    in_grant_s  = (state_q == ARB_GRANT);
    sel_valid_s = bus.s_valid_i[grant_q];
    sel_last_s  = bus.s_last_i[grant_q];
    wd_last_s   = (beat_cnt_q == CNT_WIDTH'(MAX_BEATS - 1));
    m_valid_s   = in_grant_s & sel_valid_s;
    m_last_s    = in_grant_s & (sel_last_s | wd_last_s);
    accept_s    = m_valid_s & bus.m_ready_i;
    for (int k = 0; k < N_REQ; k++) begin
      bus.s_ready_o[k] = in_grant_s & bus.m_ready_i & (grant_q == ID_WIDTH'(k));
    end
    bus.m_data_o  = data_arr_s[grant_q];
    bus.m_valid_o = m_valid_s;
    bus.m_last_o  = m_last_s;
    bus.m_id_o    = grant_q;
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until the packet ends.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (found_s) begin
          grant_d    = pick_idx_s;
          beat_cnt_d = '0;
          state_d    = ARB_GRANT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (accept_s && m_last_s) begin
          state_d    = ARB_IDLE;
          rr_ptr_d   = ID_WIDTH'(rr_next(32'(grant_q), 32'(N_REQ)));
          beat_cnt_d = '0;
          timeout_d  = ~sel_last_s;
        end else if (accept_s) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, grant, pointer, counter and timeout pulse registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy_o    = (state_q == ARB_GRANT);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios plus random
// traffic, checked every cycle against a transaction-level arbitration model.
module tb_stream_rr_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic busy_o;
  logic timeout_o;

  stream_rr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(2)) bus ();

  stream_rr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .bus       (bus.slave),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Requester sources: beats still to send, packet length, beat index, data serial.
  bit vld [N];
  int pend [N];
  int plen [N];
  int pidx [N];
  int serial [N];
  bit gaps, rnd_rdy, refill;
  bit rdy_q [$];

  // Reference model: current owner (-1 = none), search pointer, beats in packet.
  int m_owner, m_ptr, m_cnt;
  bit m_to;

  int          gseq [$];
  logic [31:0] rx_data [$];
  int          rx_cyc [$];
  int          to_cnt, last_cnt, tx_cnt, rx_cnt;
  bit          busy_prev;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_rec();
    gseq.delete();
    rx_data.delete();
    rx_cyc.delete();
    to_cnt   = 0;
    last_cnt = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (refill && pend[k] == 0 && !vld[k] && $urandom_range(7) == 0) begin
        pend[k] = int'($urandom_range(6, 1));
        plen[k] = pend[k];
        pidx[k] = 0;
      end
      if (!vld[k] && pend[k] > 0 && (!gaps || $urandom_range(2) != 0)) vld[k] = 1'b1;
      bus.s_valid_i[k]           = vld[k];
      bus.s_last_i[k]            = ((pidx[k] % plen[k]) == plen[k] - 1);
      bus.s_data_i[k*DW +: DW]   = {8'(k), 24'(serial[k])};
    end
    if (rdy_q.size() > 0) bus.m_ready_i = rdy_q.pop_front();
    else if (rnd_rdy)     bus.m_ready_i = ($urandom_range(9) < 7);
    else                  bus.m_ready_i = 1'b1;
  endtask

  task automatic check_and_advance();
    bit ev, el, acc;
    logic [N-1:0] er;
    int idx;
    ev = 1'b0; el = 1'b0; er = '0;
    if (m_owner >= 0) begin
      ev = vld[m_owner];
      if (bus.m_ready_i) er[m_owner] = 1'b1;
      el = bus.s_last_i[m_owner] || (m_cnt == MAXB - 1);
    end
    chk_eq("busy", busy_o, m_owner >= 0);
    chk_eq("timeout", timeout_o, m_to);
    chk_eq("m_valid", bus.m_valid_o, ev);
    chk_eq("s_ready", bus.s_ready_o, er);
    if (ev) begin
      chk_eq("m_last", bus.m_last_o, el);
      chk_eq("m_id", bus.m_id_o, m_owner);
      chk_eq("m_data", bus.m_data_o, {8'(m_owner), 24'(serial[m_owner])});
    end
    // Model advance for the coming clock edge.
    acc  = ev && bus.m_ready_i;
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int j = 0; j < N; j++) begin
        idx = (m_ptr + j) % N;
        if (vld[idx]) begin
          m_owner = idx;
          m_cnt   = 0;
          break;
        end
      end
    end else if (acc) begin
      if (el) begin
        m_to    = !bus.s_last_i[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
    // Observations of the DUT for scenario-level checks.
    if (bus.m_valid_o && bus.m_ready_i) begin
      rx_data.push_back(bus.m_data_o);
      rx_cyc.push_back(cyc);
      rx_cnt++;
      if (bus.m_last_o) last_cnt++;
    end
    if (timeout_o) to_cnt++;
    if (busy_o && !busy_prev) gseq.push_back(int'(bus.m_id_o));
    busy_prev = busy_o;
    for (int k = 0; k < N; k++) begin
      if (vld[k] && bus.s_ready_o[k]) begin
        tx_cnt++;
        pend[k]--;
        pidx[k]++;
        serial[k]++;
        vld[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    drive();
    #1;
    check_and_advance();
    @(posedge ACLK);
    @(negedge ACLK);
    cyc++;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    #1;
    chk_eq("rst_busy", busy_o, 1'b0);
    chk_eq("rst_valid", bus.m_valid_o, 1'b0);
    chk_eq("rst_ready", bus.s_ready_o, 4'b0000);
    chk_eq("rst_id", bus.m_id_o, 2'd0);
    chk_eq("rst_last", bus.m_last_o, 1'b0);
    chk_eq("rst_timeout", timeout_o, 1'b0);
    for (int k = 0; k < N; k++) begin
      vld[k] = 1'b0; pend[k] = 0; plen[k] = 1; pidx[k] = 0;
    end
    bus.s_valid_i = '0;
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0; busy_prev = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  initial begin
    int c0, base;
    ARESETn = 1'b0;
    bus.s_data_i = '0; bus.s_valid_i = '0; bus.s_last_i = '0; bus.m_ready_i = 1'b0;
    gaps = 1'b0; rnd_rdy = 1'b0; refill = 1'b0;
    tx_cnt = 0; rx_cnt = 0;
    for (int k = 0; k < N; k++) begin
      vld[k] = 1'b0; pend[k] = 0; plen[k] = 1; pidx[k] = 0; serial[k] = 0;
    end
    clear_rec();
    repeat (2) @(negedge ACLK);
    do_reset();
    repeat (3) tick();

    // Single requester 2, three beats.
    clear_rec();
    serial[2] = 32'hA0; pend[2] = 3; plen[2] = 3; pidx[2] = 0;
    c0 = cyc;
    repeat (6) tick();
    chk_eq("single_beats", rx_data.size(), 3);
    for (int i = 0; i < rx_data.size(); i++) begin
      chk_eq("single_data", rx_data[i], 32'h020000A0 + 32'(i));
      chk_eq("single_cycle", rx_cyc[i], c0 + 1 + i);
    end
    chk_eq("single_grants", gseq.size(), 1);
    if (gseq.size() > 0) chk_eq("single_id", gseq[0], 2);

    // Pointer now at 3: requester 3 alone, then requester 2 alone (via wrap).
    clear_rec();
    pend[3] = 1; plen[3] = 1; pidx[3] = 0;
    repeat (4) tick();
    pend[2] = 1; plen[2] = 1; pidx[2] = 0;
    repeat (4) tick();
    chk_eq("wrap_grants", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk_eq("wrap_id3", gseq[0], 3);
      chk_eq("wrap_id2", gseq[1], 2);
    end

    // Asynchronous reset in the middle of a packet.
    pend[1] = 4; plen[1] = 10; pidx[1] = 0;
    repeat (3) tick();
    chk_eq("pre_rst_busy", busy_o, 1'b1);
    #2;
    do_reset();
    repeat (3) tick();

    // All four requesters continuously valid with two-beat packets.
    clear_rec();
    for (int k = 0; k < N; k++) begin
      pend[k] = 4; plen[k] = 2; pidx[k] = 0;
    end
    repeat (28) tick();
    chk_eq("rr_grants", gseq.size(), 8);
    for (int i = 0; i < gseq.size(); i++) chk_eq("rr_order", gseq[i], i % N);
    chk_eq("rr_beats", rx_data.size(), 16);

    // Backpressure on a four-beat packet from requester 1.
    clear_rec();
    base = serial[1];
    pend[1] = 4; plen[1] = 4; pidx[1] = 0;
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    repeat (10) tick();
    chk_eq("bp_grants", gseq.size(), 1);
    if (gseq.size() > 0) chk_eq("bp_id", gseq[0], 1);
    chk_eq("bp_beats", rx_data.size(), 4);
    for (int i = 0; i < rx_data.size(); i++) chk_eq("bp_data", rx_data[i], {8'd1, 24'(base + i)});
    chk_eq("bp_lasts", last_cnt, 1);

    // Watchdog: requester 0 streams 6 beats without last, requester 1 waits.
    do_reset();
    clear_rec();
    pend[0] = 6; plen[0] = 100; pidx[0] = 0;
    pend[1] = 1; plen[1] = 1;   pidx[1] = 0;
    repeat (16) tick();
    chk_eq("wd_timeouts", to_cnt, 1);
    chk_eq("wd_beats", rx_data.size(), 7);
    chk_eq("wd_lasts", last_cnt, 2);
    chk_eq("wd_grants", gseq.size(), 3);
    if (gseq.size() == 3) begin
      chk_eq("wd_id0", gseq[0], 0);
      chk_eq("wd_id1", gseq[1], 1);
      chk_eq("wd_id2", gseq[2], 0);
    end

    // Random traffic with gaps, random backpressure and random packet lengths.
    do_reset();
    clear_rec();
    tx_cnt = 0; rx_cnt = 0;
    gaps = 1'b1; rnd_rdy = 1'b1; refill = 1'b1;
    repeat (3000) tick();
    refill = 1'b0;
    repeat (300) tick();
    chk_eq("rand_txrx", rx_cnt, tx_cnt);
    chk_eq("rand_wd_seen", to_cnt > 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
